// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer for the 5-stage core: load-use stalls, redirect flushes
// with a programmable refetch penalty, data-memory wait freezes and saturating perf counters.
module hazard_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [6:0]       ID_Opcode,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             EX_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0]       RELOAD  = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic rs1_used, rs2_used, load_use, mem_stall, flush_accept;

  assign rs1_used  = !(ID_Opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used  = ID_Opcode inside {OP_REG, OP_STORE, OP_BRANCH};
  assign load_use  = EX_MemRead && (EX_rd != 5'd0) &&
                     ((rs1_used && (EX_rd == ID_rs1)) || (rs2_used && (EX_rd == ID_rs2)));
  assign mem_stall = mem_req && !mem_ready;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      remaining_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    flush_accept = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
        end else if (EX_redirect) begin
          flush_accept = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            remaining_d = RELOAD;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        // A memory freeze parks the flush sequence without consuming a cycle of it.
        if (mem_stall) begin
          state_d = ST_FLUSH;
        end else if (EX_redirect) begin
          flush_accept = 1'b1;
          remaining_d  = RELOAD;
        end else if (remaining_q == 4'd1) begin
          state_d = ST_RUN;
        end else begin
          remaining_d = remaining_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_Flush     = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    busy         = 1'b0;
    if (reset) begin
      // Drain NOPs into every stage while the PC is held.
      PC_Write    = 1'b0;
      IF_Flush    = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      busy = (state_q != ST_RUN);
      if (mem_stall) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (EX_redirect) begin
              IF_Flush    = 1'b1;
              ID_EX_Flush = 1'b1;
            end else if (load_use) begin
              PC_Write    = 1'b0;
              IF_ID_Write = 1'b0;
              ID_EX_Flush = 1'b1;
            end
          end
          ST_FLUSH: begin
            IF_Flush    = 1'b1;
            ID_EX_Flush = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!PC_Write && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + CNT_ONE;
    if (flush_accept && (flush_count_q != CNT_MAX)) flush_count_d = flush_count_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central pipeline-control block for the 5-stage RISC-V core. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It sequences three hazard types: load-use stalls, taken-branch/jump flushes with a configurable refetch penalty, and multi-cycle data-memory waits. It also keeps saturating performance counters for stall cycles and flush events.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID and ID/EX are flushed per redirect (1..15)
CNT_W, 16, width of the performance counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ID_rs1  input  5  rs1 field of the instruction in ID
ID_rs2  input  5  rs2 field of the instruction in ID
ID_Opcode  input  7  opcode of the instruction in ID
EX_MemRead  input  1  instruction in EX is a load
EX_rd  input  5  destination register of the instruction in EX
EX_redirect  input  1  taken branch or jump resolved in EX this cycle
mem_req  input  1  instruction in MEM is accessing data memory
mem_ready  input  1  data memory completes the access this cycle
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register write enable
IF_Flush  output  1  IF/ID loads a NOP (takes effect only with IF_ID_Write=1)
ID_EX_Write  output  1  ID/EX register write enable
ID_EX_Flush  output  1  ID/EX loads a bubble (all control bits 0)
EX_MEM_Write  output  1  EX/MEM register write enable
busy  output  1  high while in MEM_WAIT or FLUSH
stall_count  output  CNT_W  cycles with PC_Write=0 since reset, saturating
flush_count  output  CNT_W  number of redirects accepted since reset, saturating

Behaviour:
- One clock domain. Reset is synchronous and active-high. Port names are clock and reset.
- Control outputs are combinational functions of state, inputs and reset. Counters and state are registered.
- While reset=1, the outputs are:
  - PC_Write=0, IF_ID_Write=1, IF_Flush=1, ID_EX_Write=1, ID_EX_Flush=1, EX_MEM_Write=1, busy=0.
  - This drains NOPs into the pipeline.
- On a reset edge: state<=RUN, flush counter<=0, stall_count<=0, flush_count<=0.
- Reset mid-MEM_WAIT or mid-FLUSH aborts the sequence immediately.
- Register usage by opcode:
  - rs1 is used unless the opcode is 0110111, 0010111 or 1101111.
  - rs2 is used only for 0110011, 0100011 and 1100011.
- load_use = EX_MemRead & EX_rd!=0 & ((rs1 used & EX_rd==ID_rs1) | (rs2 used & EX_rd==ID_rs2)).
- mem_stall = mem_req & ~mem_ready.
- Default (no hazard): all write enables = 1, all flushes = 0.
- Priority within a cycle: mem_stall > redirect/FLUSH > load_use.
- States: RUN, MEM_WAIT, FLUSH.
- RUN:
  - If mem_stall: PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write = 0; next state MEM_WAIT. A concurrent EX_redirect is ignored; EX is frozen, so it re-presents after the wait.
  - Else if EX_redirect: PC_Write=1, IF_ID_Write=1, IF_Flush=1, ID_EX_Flush=1; flush_count+1. If FLUSH_CYCLES>1, next state FLUSH with remaining=FLUSH_CYCLES-1.
  - Else if load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Lasts one cycle and stays in RUN.
- MEM_WAIT:
  - All four write enables stay 0 while mem_stall.
  - The first cycle with mem_ready=1 (or mem_req=0) gives default outputs and returns to RUN.
  - No redirect or load_use action is taken in this state.
- FLUSH:
  - IF_ID_Write=1, IF_Flush=1, ID_EX_Flush=1, PC_Write=1.
  - remaining decrements each cycle; at remaining==1, next state is RUN.
  - mem_stall has priority: freeze as in MEM_WAIT without decrementing, then resume FLUSH.
  - A new EX_redirect reloads remaining=FLUSH_CYCLES-1 and increments flush_count.
- stall_count increments in every non-reset cycle with PC_Write=0. It holds at 2^CNT_W-1.
- flush_count saturates the same way.

Test Plan:
- Reset for 2 cycles → PC_Write=0, IF_Flush=1, ID_EX_Flush=1. After release in RUN with no hazards → all write enables 1, counters 0.
- lw x5 in EX (EX_MemRead=1, EX_rd=5); add x6,x5,x7 in ID (ID_Opcode=0110011, ID_rs1=5) → exactly one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_count=1. Repeat with EX_rd=0 or ID_Opcode=0110111 → no stall.
- EX_redirect pulse with FLUSH_CYCLES=3 → IF_Flush=1 and ID_EX_Flush=1 for 3 consecutive cycles, busy=1 for cycles 2-3, flush_count=1.
- mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → all write enables 0 for 4 cycles, then 1; stall_count=4.
- EX_redirect and load_use in the same cycle → flush only, no load-use stall. EX_redirect and mem_stall in the same cycle → freeze only; flush_count unchanged until the redirect re-presents after the wait.
- Assert reset during FLUSH (remaining=2) → next cycle state is RUN and counters are 0. CNT_W=4 with 20 stall cycles → stall_count holds at 15.
